// File: rtl/axi4_lite_mem_slave_pkg.sv
// Shared constants for the AXI4-Lite memory responder.
// Response codes and the write/read FSM encodings.
package axi4_lite_mem_slave_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_COMMIT = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

endpackage

// File: rtl/axi4_lite_mem_slave_bram_be.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// Same-address collision is read-first; contents survive reset.
module axi4_lite_mem_slave_bram_be #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write on port A
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Registered read on port B; holds its value while re is low
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite responder over a word-addressed on-chip memory.
// Independent write and read FSMs share one dual-port RAM.
module axi4_lite_mem_slave
    import axi4_lite_mem_slave_pkg::*;
#(
    parameter int C_S00_AXI_ADDR_WIDTH = 32,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH            = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready
);

    localparam int AW    = C_S00_AXI_ADDR_WIDTH;
    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [1:0]    w_state;
    logic [AW-1:0] aw_addr;
    logic [31:0]   w_data;
    logic [3:0]    w_strb;
    logic          aw_done;
    logic          w_done;
    logic          w_oor;
    logic          mem_we;

    logic [1:0]    r_state;
    logic [AW-1:0] ar_addr;
    logic          r_oor;
    logic [31:0]   mem_q;

    // A channel counts as captured once its ready has dropped,
    // or if its handshake happens this very cycle.
    assign aw_done = !s00_axi_awready || s00_axi_awvalid;
    assign w_done  = !s00_axi_wready  || s00_axi_wvalid;

    // Anything above the last word is out of range
    assign w_oor = |aw_addr[AW-1:IDX_W+2];
    assign r_oor = |ar_addr[AW-1:IDX_W+2];

    // A reset landing on the commit cycle cancels the write
    assign mem_we = (w_state == W_COMMIT) && !w_oor && !reset;

    // Out-of-range reads return zero data
    assign s00_axi_rdata = (s00_axi_rresp == AXI_RESP_SLVERR) ? '0 : mem_q;

    logic unused_bits;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                           aw_addr[1:0], ar_addr[1:0]};

    // Write channel: capture AW and W in any order, commit, respond
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state         <= W_IDLE;
            s00_axi_awready <= 1'b1;
            s00_axi_wready  <= 1'b1;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= AXI_RESP_OKAY;
            aw_addr         <= '0;
            w_data          <= '0;
            w_strb          <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s00_axi_awvalid && s00_axi_awready) begin
                        aw_addr         <= s00_axi_awaddr;
                        s00_axi_awready <= 1'b0;
                    end
                    if (s00_axi_wvalid && s00_axi_wready) begin
                        w_data         <= s00_axi_wdata;
                        w_strb         <= s00_axi_wstrb;
                        s00_axi_wready <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        w_state <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    s00_axi_bresp  <= w_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    s00_axi_bvalid <= 1'b1;
                    w_state        <= W_RESP;
                end
                W_RESP: begin
                    if (s00_axi_bready) begin
                        s00_axi_bvalid  <= 1'b0;
                        s00_axi_awready <= 1'b1;
                        s00_axi_wready  <= 1'b1;
                        w_state         <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read channel: latch address, one-cycle fetch, hold data until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= R_IDLE;
            s00_axi_arready <= 1'b1;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rresp   <= AXI_RESP_OKAY;
            ar_addr         <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s00_axi_arvalid) begin
                        ar_addr         <= s00_axi_araddr;
                        s00_axi_arready <= 1'b0;
                        r_state         <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    s00_axi_rresp  <= r_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    s00_axi_rvalid <= 1'b1;
                    r_state        <= R_DATA;
                end
                R_DATA: begin
                    if (s00_axi_rready) begin
                        s00_axi_rvalid  <= 1'b0;
                        s00_axi_arready <= 1'b1;
                        r_state         <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    axi4_lite_mem_slave_bram_be #(
        .DEPTH (MEM_DEPTH)
    ) u_bram (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .be    (w_strb),
        .waddr (aw_addr[IDX_W+1:2]),
        .wdata (w_data),
        .re    (r_state == R_FETCH),
        .raddr (ar_addr[IDX_W+1:2]),
        .rdata (mem_q)
    );

endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// Directed self-checking bench for axi4_lite_mem_slave.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_axi4_lite_mem_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  resp;
    logic [31:0] data;

    always #5 clk = ~clk;

    axi4_lite_mem_slave dut (
        .clk             (clk),
        .reset           (reset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [1:0] r);
        int  n;
        logic ha;
        logic hw;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            ha = awvalid && awready;
            hw = wvalid && wready;
            step();
            if (ha) awvalid = 1'b0;
            if (hw) wvalid = 1'b0;
            n++;
        end
        check("wr_accept", {30'd0, awvalid, wvalid}, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            step();
            n++;
        end
        check("wr_bvalid", {31'd0, bvalid}, 32'd1);
        r = bresp;
        step();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d,
                      output logic [1:0] r);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            step();
            n++;
        end
        check("rd_arready", {31'd0, arready}, 32'd1);
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            step();
            n++;
        end
        check("rd_rvalid", {31'd0, rvalid}, 32'd1);
        d = rdata;
        r = rresp;
        step();
    endtask

    initial begin
        reset = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("rst_awready", {31'd0, awready}, 32'd1);
        check("rst_wready",  {31'd0, wready},  32'd1);
        check("rst_arready", {31'd0, arready}, 32'd1);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_bresp",   {30'd0, bresp},   32'd0);
        check("rst_rresp",   {30'd0, rresp},   32'd0);
        check("rst_rdata",   rdata,            32'd0);

        // 1: same-cycle AW/W, exact latency
        awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t1_commit_bvalid", {31'd0, bvalid}, 32'd0);
        check("t1_commit_awready", {31'd0, awready}, 32'd0);
        step();
        check("t1_bvalid", {31'd0, bvalid}, 32'd1);
        check("t1_bresp",  {30'd0, bresp},  32'd0);
        step();
        check("t1_bdone",   {31'd0, bvalid},  32'd0);
        check("t1_awready", {31'd0, awready}, 32'd1);
        araddr = 32'h10; arvalid = 1'b1; rready = 1'b1;
        step();
        arvalid = 1'b0;
        check("t1_fetch_rvalid", {31'd0, rvalid}, 32'd0);
        step();
        check("t1_rvalid", {31'd0, rvalid}, 32'd1);
        check("t1_rdata",  rdata,           32'hDEADBEEF);
        check("t1_rresp",  {30'd0, rresp},  32'd0);
        step();
        check("t1_rdone", {31'd0, rvalid}, 32'd0);

        // wstrb = 0 leaves memory alone but answers OKAY
        wr(32'h10, 32'hFFFFFFFF, 4'h0, resp);
        check("strb0_bresp", {30'd0, resp}, 32'd0);
        rd(32'h10, data, resp);
        check("strb0_rdata", data, 32'hDEADBEEF);

        // 2: W three cycles ahead of AW, then a partial-strobe write
        wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        step();
        wvalid = 1'b0;
        check("t2_wready_held", {31'd0, wready}, 32'd0);
        check("t2_awready_open", {31'd0, awready}, 32'd1);
        step();
        step();
        check("t2_no_bvalid", {31'd0, bvalid}, 32'd0);
        awaddr = 32'h20; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        step();
        check("t2_bvalid", {31'd0, bvalid}, 32'd1);
        check("t2_bresp",  {30'd0, bresp},  32'd0);
        step();
        wr(32'h20, 32'hAABBCCDD, 4'b0101, resp);
        check("t2_strb_bresp", {30'd0, resp}, 32'd0);
        rd(32'h20, data, resp);
        check("t2_merge_rdata", data, 32'h11BB33DD);

        // 3: out-of-range write dropped, read returns SLVERR and zero
        wr(32'h30, 32'h12345678, 4'hF, resp);
        check("t3_ok_bresp", {30'd0, resp}, 32'd0);
        wr(32'h1000, 32'h0, 4'hF, resp);
        check("t3_oor_bresp", {30'd0, resp}, 32'd2);
        rd(32'h30, data, resp);
        check("t3_keep_rdata", data, 32'h12345678);
        check("t3_keep_rresp", {30'd0, resp}, 32'd0);
        rd(32'h1000, data, resp);
        check("t3_oor_rdata", data, 32'd0);
        check("t3_oor_rresp", {30'd0, resp}, 32'd2);

        // 4: backpressure on both response channels
        bready = 1'b0; rready = 1'b0;
        awaddr = 32'h40; wdata = 32'h55AA55AA; wstrb = 4'hF;
        araddr = 32'h10;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("t4_bvalid",  {31'd0, bvalid},  32'd1);
            check("t4_rvalid",  {31'd0, rvalid},  32'd1);
            check("t4_bresp",   {30'd0, bresp},   32'd0);
            check("t4_rdata",   rdata,            32'hDEADBEEF);
            check("t4_awready", {31'd0, awready}, 32'd0);
            check("t4_arready", {31'd0, arready}, 32'd0);
            step();
        end
        bready = 1'b1; rready = 1'b1;
        step();
        check("t4_bdone",   {31'd0, bvalid},  32'd0);
        check("t4_rdone",   {31'd0, rvalid},  32'd0);
        check("t4_awready_back", {31'd0, awready}, 32'd1);
        check("t4_arready_back", {31'd0, arready}, 32'd1);
        rd(32'h40, data, resp);
        check("t4_next_rdata", data, 32'h55AA55AA);

        // 5: commit and fetch of the same word in one cycle read old data
        wr(32'h50, 32'h0, 4'hF, resp);
        awaddr = 32'h50; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        araddr = 32'h50;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        bready = 1'b1; rready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        step();
        check("t5_rvalid", {31'd0, rvalid}, 32'd1);
        check("t5_old_rdata", rdata, 32'd0);
        check("t5_bvalid", {31'd0, bvalid}, 32'd1);
        step();
        rd(32'h50, data, resp);
        check("t5_new_rdata", data, 32'hCAFEF00D);

        // 6: reset while holding both responses
        bready = 1'b0; rready = 1'b0;
        awaddr = 32'h60; wdata = 32'h0BADF00D; wstrb = 4'hF;
        araddr = 32'h50;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        step();
        check("t6_pre_bvalid", {31'd0, bvalid}, 32'd1);
        check("t6_pre_rvalid", {31'd0, rvalid}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_bvalid",  {31'd0, bvalid},  32'd0);
        check("t6_rvalid",  {31'd0, rvalid},  32'd0);
        check("t6_awready", {31'd0, awready}, 32'd1);
        check("t6_wready",  {31'd0, wready},  32'd1);
        check("t6_arready", {31'd0, arready}, 32'd1);
        rd(32'h60, data, resp);
        check("t6_kept_rdata", data, 32'h0BADF00D);

        // Reset during the commit cycle cancels that write
        wr(32'h70, 32'h77777777, 4'hF, resp);
        awaddr = 32'h70; wdata = 32'h88888888; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t7_bvalid", {31'd0, bvalid}, 32'd0);
        rd(32'h70, data, resp);
        check("t7_cancel_rdata", data, 32'h77777777);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_mem_slave.md
# axi4_lite_mem_slave

AXI4-Lite responder backed by a word-addressed on-chip memory. It is the far end of the systolic array's AXI4-Lite master port and stands in for off-chip memory in simulation and FPGA bring-up. Activation and weight tiles are held here for LOAD instructions, and results land here on WRITE instructions. Write and read channels run independent state machines; both share one dual-port memory.

## Interface
Parameters:
- `C_S00_AXI_ADDR_WIDTH`, 32, byte-address width.
- `C_S00_AXI_DATA_WIDTH`, 32, data width. Only 32 is supported.
- `MEM_DEPTH`, 1024, number of 32-bit words. Must be a power of two.

Ports:
- `clk`  in  1  single clock for everything.
- `reset`  in  1  synchronous, active-high reset.
- `s00_axi_awaddr`  in  ADDR_WIDTH  write address.
- `s00_axi_awprot`  in  3  ignored.
- `s00_axi_awvalid` in 1, `s00_axi_awready` out 1: write-address handshake.
- `s00_axi_wdata`  in  32  write data.
- `s00_axi_wstrb`  in  4  byte enables.
- `s00_axi_wvalid` in 1, `s00_axi_wready` out 1: write-data handshake.
- `s00_axi_bresp`  out  2  write response.
- `s00_axi_bvalid` out 1, `s00_axi_bready` in 1: write-response handshake.
- `s00_axi_araddr`  in  ADDR_WIDTH  read address.
- `s00_axi_arprot`  in  3  ignored.
- `s00_axi_arvalid` in 1, `s00_axi_arready` out 1: read-address handshake.
- `s00_axi_rdata`  out  32  read data.
- `s00_axi_rresp`  out  2  read response.
- `s00_axi_rvalid` out 1, `s00_axi_rready` in 1: read-data handshake.

## Operation
- Address decode:
  - Word index = `addr[log2(MEM_DEPTH)+1:2]`. `addr[1:0]` is ignored.
  - An address ≥ MEM_DEPTH*4 is out of range. It returns SLVERR (2'b10), the write is dropped, and rdata is 0.
  - In-range accesses return OKAY (2'b00).
- Write FSM states: W_IDLE → W_COMMIT → W_RESP.
  - W_IDLE:
    - awready and wready are each high until that channel's beat is captured. AW and W may arrive in the same cycle or in either order.
    - The captured address and data/strobe are held in registers.
    - Once both are captured, go to W_COMMIT.
  - W_COMMIT (1 cycle): memory write with byte enables = wstrb, unless the address is out of range. Compute bresp. Go to W_RESP.
  - W_RESP:
    - bvalid is high and bresp is stable until bready.
    - The cycle bvalid && bready are both high is the handshake; return to W_IDLE.
    - A new AW/W is not accepted before that handshake.
- Read FSM states: R_IDLE → R_FETCH → R_DATA.
  - R_IDLE: arready high. An arvalid && arready handshake latches the address; go to R_FETCH.
  - R_FETCH: synchronous memory read (1 cycle).
  - R_DATA:
    - rvalid is high; rdata and rresp are registered and held stable until rready.
    - On the handshake, return to R_IDLE.
- Outstanding transactions: at most one write and one read in flight; the two are fully concurrent.
- Collision: a W_COMMIT write and an R_FETCH read of the same word in the same cycle is read-first (the read returns the old data).
- wstrb = 0 with an in-range address: memory unchanged, bresp = OKAY.

## Timing
- Reset values, the cycle after `reset` is sampled high:
  - awready = wready = arready = 1.
  - bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0.
  - Both FSMs in their IDLE states.
- Write latency: the last of AW/W handshakes in cycle t → memory written at the end of t+1 → bvalid high in t+2.
- Read latency: AR handshake in cycle t → rvalid high in t+2.
- Back-to-back throughput with bready/rready tied high: one write per 3 cycles and one read per 3 cycles.
- Reset mid-transaction:
  - Any pending AW/W/AR capture is discarded; bvalid and rvalid drop.
  - Memory contents are retained, and a write in W_COMMIT during reset is not performed.
  - The master must also be reset. Behaviour is defined only when both ends are reset together.
- No combinational path from any input to any output. All ready/valid/resp/data outputs are registered.

## Structure
- Add to shared package `sa_share.v`:
  - `AXI_RESP_OKAY` = 2'b00, `AXI_RESP_SLVERR` = 2'b10.
  - Write-FSM encodings `W_IDLE`/`W_COMMIT`/`W_RESP`.
  - Read-FSM encodings `R_IDLE`/`R_FETCH`/`R_DATA`.
- Sub-module `BRAM_BE`: simple dual-port RAM.
  - Port A: write with 4 byte enables. Port B: registered read.
  - Read-first on a same-address collision.
  - The generic BRAM has no byte enables, so it is not reused.
- Top holds both FSMs, capture registers, and the range check. Target size: ~200 lines.

## Test plan
1. Reset, then AW addr=0x10 and W data=0xDEADBEEF, strb=4'hF, in the same cycle → bvalid two cycles later with bresp=00. AR 0x10 → rvalid two cycles later, rdata=0xDEADBEEF, rresp=00.
2. W beat issued 3 cycles before its AW (addr 0x20, data 0x11223344), then a strb=4'b0101 write of 0xAABBCCDD to 0x20 → read of 0x20 returns 0x11BB33DD.
3. Write 0x12345678 to 0x30, then AW/W of 0x0 to address MEM_DEPTH*4 → bresp=10 and read of 0x30 still 0x12345678. AR to MEM_DEPTH*4 → rresp=10, rdata=0.
4. Backpressure: bready=0 and rready=0 held 5 cycles → bvalid/rvalid stay high with bresp/rdata stable, awready=arready=0 throughout. Releasing them completes the handshakes and the next transaction is accepted.
5. Concurrent write of 0xCAFEF00D and read to the same word (old value 0x0) aligned so W_COMMIT coincides with R_FETCH → read returns 0x0. A following read returns 0xCAFEF00D.
6. Assert reset while in W_RESP and R_DATA → next cycle bvalid=rvalid=0 and awready=wready=arready=1. A subsequent read returns the previously committed data.
